// File: rtl/distribute_pkg.sv
// Shared constants, slot state type and helpers for the 1-to-4 distributor.
package distribute_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int NUM_SLOTS     = 4;

    localparam logic [1:0] SLOT_1 = 2'b00;
    localparam logic [1:0] SLOT_2 = 2'b01;
    localparam logic [1:0] SLOT_3 = 2'b10;
    localparam logic [1:0] SLOT_4 = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [2:0] popcount4(input logic [NUM_SLOTS-1:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/distribute_4_if.sv
// Producer/consumer bundle of the 1-to-4 distributor.
// The bcast signal exists only when DISTRIBUTE_BCAST_EN is defined.
interface distribute_4_if #(
    parameter int WIDTH = distribute_pkg::DEFAULT_WIDTH
) ();
    logic [WIDTH-1:0] data_r;
    logic [1:0]       selector;
    logic             in_valid;
    logic             in_ready;
`ifdef DISTRIBUTE_BCAST_EN
    logic             bcast;
`endif
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] data_3;
    logic [WIDTH-1:0] data_4;
    logic [3:0]       valid_w;
    logic [3:0]       ack_w;
    logic [2:0]       occupancy;

    modport master (
        output data_r, selector, in_valid, ack_w,
`ifdef DISTRIBUTE_BCAST_EN
        output bcast,
`endif
        input  in_ready, data_1, data_2, data_3, data_4, valid_w, occupancy
    );

    modport slave (
        input  data_r, selector, in_valid, ack_w,
`ifdef DISTRIBUTE_BCAST_EN
        input  bcast,
`endif
        output in_ready, data_1, data_2, data_3, data_4, valid_w, occupancy
    );
endinterface

// File: rtl/distribute_4_slot.sv
// Single-entry holding slot: one data register plus an EMPTY/FULL flag.
//   state      | meaning
//   SLOT_EMPTY | no unconsumed word; ack is ignored
//   SLOT_FULL  | word held until acked; load with ack keeps it full
module distribute_slot
    import distribute_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Load wins over ack so a slot can turn over one word per cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = d_i;
        end else if (ack_i && (state_q == SLOT_FULL)) begin
            state_d = SLOT_EMPTY;
        end
    end

    assign q_o     = data_q;
    assign valid_o = (state_q == SLOT_FULL);

endmodule

// File: rtl/distribute_4.sv
// 1-to-4 registered distributor: selector decode, in_ready and occupancy.
// Optional broadcast write enabled by DISTRIBUTE_BCAST_EN.
module distribute_4
    import distribute_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    distribute_4_if.slave  bus
);

    logic [NUM_SLOTS-1:0] valid_w;
    logic [NUM_SLOTS-1:0] target;
    logic [NUM_SLOTS-1:0] load;
    logic [NUM_SLOTS-1:0] valid_nxt;
    logic                 in_ready;
    logic [2:0]           occupancy_q, occupancy_d;
    logic [WIDTH-1:0]     slot_q [NUM_SLOTS];

    always_comb begin
        target   = '0;
        in_ready = ~valid_w[bus.selector] | bus.ack_w[bus.selector];
        for (int k = 0; k < NUM_SLOTS; k++) begin
            target[k] = (bus.selector == 2'(k));
        end
`ifdef DISTRIBUTE_BCAST_EN
        if (bus.bcast) begin
            target   = '1;
            in_ready = &(~valid_w | bus.ack_w);
        end
`endif
    end

    assign load      = {NUM_SLOTS{bus.in_valid & in_ready}} & target;
    assign valid_nxt = load | (valid_w & ~bus.ack_w);

    // Counted from next-state flags so it changes on the same edge as valid_w.
    assign occupancy_d = popcount4(valid_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        distribute_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[k]),
            .ack_i   (bus.ack_w[k]),
            .d_i     (bus.data_r),
            .q_o     (slot_q[k]),
            .valid_o (valid_w[k])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.valid_w   = valid_w;
    assign bus.occupancy = occupancy_q;
    assign bus.data_1    = slot_q[SLOT_1];
    assign bus.data_2    = slot_q[SLOT_2];
    assign bus.data_3    = slot_q[SLOT_3];
    assign bus.data_4    = slot_q[SLOT_4];

endmodule

// File: tb/tb_distribute_4.sv
// Self-checking bench for distribute_4: directed steps plus random traffic
// compared against a slot-array reference model.
module tb_distribute_4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] md [4];
    bit          mv [4];

    distribute_4_if bus_if ();

    distribute_4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = mv[k];
        return v;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int k = 0; k < 4; k++) if (mv[k]) n++;
        return n;
    endfunction

    function automatic bit model_ready(input logic [1:0] s, input logic [3:0] a, input bit b);
        bit r = 1'b1;
        if (b) begin
            for (int k = 0; k < 4; k++) if (mv[k] && !a[k]) r = 1'b0;
        end else begin
            r = !mv[s] || a[s];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            md[k] = '0;
            mv[k] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_w"}, 32'(bus_if.valid_w), 32'(model_valid()));
        chk({tag, ".occupancy"}, 32'(bus_if.occupancy), 32'(model_count()));
        chk({tag, ".data_1"}, bus_if.data_1, md[0]);
        chk({tag, ".data_2"}, bus_if.data_2, md[1]);
        chk({tag, ".data_3"}, bus_if.data_3, md[2]);
        chk({tag, ".data_4"}, bus_if.data_4, md[3]);
    endtask

    // Called just after a rising edge: drive, check ready, clock, check state.
    task automatic step(input string tag, input bit v, input logic [1:0] s,
                        input logic [31:0] d, input logic [3:0] a, input bit b);
        bit acc;
        bus_if.in_valid = v;
        bus_if.selector = s;
        bus_if.data_r   = d;
        bus_if.ack_w    = a;
`ifdef DISTRIBUTE_BCAST_EN
        bus_if.bcast    = b;
`endif
        #1;
        acc = v && model_ready(s, a, b);
        chk({tag, ".in_ready"}, 32'(bus_if.in_ready), 32'(model_ready(s, a, b)));
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (acc && (b || (s == 2'(k)))) begin
                md[k] = d;
                mv[k] = 1'b1;
            end else if (a[k]) begin
                mv[k] = 1'b0;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.selector = 2'b00;
        bus_if.data_r   = '0;
        bus_if.ack_w    = '0;
`ifdef DISTRIBUTE_BCAST_EN
        bus_if.bcast    = 1'b0;
`endif
        model_reset();

        #1;
        check_all("reset");
        chk("reset.in_ready", 32'(bus_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First accept appears one cycle later in slot 3
        step("accept3", 1'b1, 2'b10, 32'hDEADBEEF, 4'b0000, 1'b0);
        chk("accept3.valid_const", 32'(bus_if.valid_w), 32'h4);
        chk("accept3.data_const", bus_if.data_3, 32'hDEADBEEF);
        chk("accept3.occ_const", 32'(bus_if.occupancy), 32'd1);
        step("drain3", 1'b0, 2'b00, 32'h0, 4'b0100, 1'b0);

        // Blocked on full slot 1, then ack and accept on the same edge
        step("fill1", 1'b1, 2'b00, 32'h1111_AAAA, 4'b0000, 1'b0);
        step("blocked1", 1'b1, 2'b00, 32'h2222_BBBB, 4'b0000, 1'b0);
        chk("blocked1.data_1_kept", bus_if.data_1, 32'h1111_AAAA);
        step("ackload1", 1'b1, 2'b00, 32'h2222_BBBB, 4'b0001, 1'b0);
        chk("ackload1.data_1_new", bus_if.data_1, 32'h2222_BBBB);
        chk("ackload1.valid0", 32'(bus_if.valid_w[0]), 32'd1);

        // Back-to-back stream into slot 2 with its ack held high
        for (int i = 0; i < 8; i++) begin
            step("stream2", 1'b1, 2'b01, 32'hC0DE_0000 + 32'(i), 4'b0010, 1'b0);
            chk("stream2.data_2", bus_if.data_2, 32'hC0DE_0000 + 32'(i));
        end
        step("stream2_end", 1'b0, 2'b01, 32'h0, 4'b0010, 1'b0);

        // Ack on empty slot 4 changes nothing
        step("ack_empty4", 1'b0, 2'b11, 32'h0, 4'b1000, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), 1'b0);
        end

        // Fill everything, then reset asynchronously in the middle of a cycle
        step("clr", 1'b0, 2'b00, 32'h0, 4'b1111, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step("fillall", 1'b1, 2'(k), 32'h5A5A_0000 + 32'(k), 4'b0000, 1'b0);
        end
        chk("fillall.occ4", 32'(bus_if.occupancy), 32'd4);
        bus_if.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.in_ready", 32'(bus_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 1'b1, 2'b11, 32'h0BAD_F00D, 4'b0000, 1'b0);

`ifdef DISTRIBUTE_BCAST_EN
        step("bc_clr", 1'b0, 2'b00, 32'h0, 4'b1111, 1'b0);
        step("bcast", 1'b1, 2'b10, 32'h0000_0001, 4'b0000, 1'b1);
        chk("bcast.valid_const", 32'(bus_if.valid_w), 32'hF);
        chk("bcast.occ_const", 32'(bus_if.occupancy), 32'd4);
        step("bcast_blk", 1'b1, 2'b00, 32'h0000_0002, 4'b0111, 1'b1);
        step("bcast_blk2", 1'b1, 2'b00, 32'h0000_0002, 4'b0000, 1'b1);
        step("bcast_ok", 1'b1, 2'b00, 32'h0000_0002, 4'b1000, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step("bc_rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
